// File: rtl/hub75_capture.sv
// HUB75 receiver / panel emulator: counts, per pixel and channel, the latched row periods in which it was lit.
// Optional HUB75_CAPTURE_SYNC_EN: 2-flop synchronizers on every HUB75 input (adds 2 cycles, keeps alignment).
module hub75_capture #(
    parameter int          ROWS     = 64,
    parameter int          COLS     = 64,
    parameter logic [31:0] BASEADDR = 32'h8200_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 addr,
    input  logic [31:0]                 wdata,
    input  logic [3:0]                  wmask,
    input  logic                        wen,
    input  logic                        ren,
    output logic [31:0]                 rdata,
    output logic                        ready,
    output logic                        active,
    input  logic                        R0,
    input  logic                        G0,
    input  logic                        B0,
    input  logic                        R1,
    input  logic                        G1,
    input  logic                        B1,
    input  logic [$clog2(ROWS/2)-1:0]   ROWSEL,
    input  logic                        CLK_HUB75,
    input  logic                        LATCH,
    input  logic                        OE
);
    localparam int HR    = ROWS / 2;
    localparam int RAW   = $clog2(HR);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int AW    = RAW + CW;
    localparam int DEPTH = HR * COLS;
    localparam int SCW   = $clog2(COLS + 2);
    localparam int NPIX  = ROWS * COLS;
    localparam logic [29:0] CTL_WORD = 30'(NPIX);
    localparam logic [29:0] CNT_WORD = 30'(NPIX + 1);
    localparam logic [31:0] SPAN     = 32'(4 * (NPIX + 2));

    // Each 8-bit {B,G,R} field adds its channel bit and sticks at 255.
    function automatic logic [23:0] sat_acc(input logic [23:0] cur, input logic [2:0] bgr);
        logic [23:0] nxt;
        nxt = cur;
        for (int f = 0; f < 3; f++) begin
            nxt[8*f +: 8] = (cur[8*f +: 8] == 8'hFF) ? 8'hFF : cur[8*f +: 8] + 8'(bgr[f]);
        end
        return nxt;
    endfunction

    // rgb_s bit order: 0=R0 1=G0 2=B0 3=R1 4=G1 5=B1
    logic [5:0]     rgb_s;
    logic [RAW-1:0] rowsel_s;
    logic           hclk_s, latch_s, oe_s;

`ifdef HUB75_CAPTURE_SYNC_EN
    localparam int SW = 9 + RAW;
    logic [SW-1:0] sync_p0, sync_p1;
    always_ff @(posedge clk) begin
        sync_p0 <= {B1, G1, R1, B0, G0, R0, ROWSEL, CLK_HUB75, LATCH, OE};
        sync_p1 <= sync_p0;
    end
    assign {rgb_s, rowsel_s, hclk_s, latch_s, oe_s} = sync_p1;
`else
    assign {rgb_s, rowsel_s, hclk_s, latch_s, oe_s} = {B1, G1, R1, B0, G0, R0, ROWSEL, CLK_HUB75, LATCH, OE};
`endif

    logic hclk_prev, latch_prev;
    logic shift_rise, latch_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hclk_prev  <= 1'b0;
            latch_prev <= 1'b0;
        end else begin
            hclk_prev  <= hclk_s;
            latch_prev <= latch_s;
        end
    end

    assign shift_rise = hclk_s & ~hclk_prev;
    assign latch_rise = latch_s & ~latch_prev;

    // Bus decode
    typedef enum logic [1:0] {B_IDLE, B_PIX, B_DONE} bus_state_t;
    bus_state_t bstate;

    logic [31:0]      off;
    logic [29:0]      word;
    logic [ROW_W-1:0] pix_row;
    logic [AW-1:0]    pix_addr;
    logic             pix_half, is_pix, bus_go, is_rd, is_wr;
    logic             ctl_wr, cnt_wr, clr_start;

    assign off      = addr - BASEADDR;
    assign active   = (addr >= BASEADDR) && (off < SPAN);
    assign word     = off[31:2];
    assign is_pix   = word < 30'(NPIX);
    assign pix_row  = word[CW +: ROW_W];
    assign pix_half = pix_row[ROW_W-1];
    assign pix_addr = {pix_row[RAW-1:0], word[CW-1:0]};
    assign bus_go   = (bstate == B_IDLE) && active;
    assign is_rd    = bus_go && ren;
    assign is_wr    = bus_go && wen && !ren;
    assign ctl_wr   = is_wr && (word == CTL_WORD);
    assign cnt_wr   = is_wr && (word == CNT_WORD);
    assign clr_start = ctl_wr && wmask[0] && wdata[1];

    logic unused_bits;
    assign unused_bits = ^{wdata[31:11], wdata[8:2], wmask[3:2]};

    // Control, flags and shift bookkeeping
    logic           en, ovr, sovf;
    logic [SCW-1:0] scnt;
    logic [15:0]    lcount;
    logic           clr_busy, vld_p0, vld_p1, acc_busy, busy;
    logic           lat_go, lat_drop;

    assign acc_busy = vld_p0 | vld_p1;
    assign busy     = clr_busy | acc_busy;
    assign lat_go   = latch_rise && en && !busy && !clr_start;
    assign lat_drop = latch_rise && en && !clr_busy && acc_busy && !clr_start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en     <= 1'b0;
            ovr    <= 1'b0;
            sovf   <= 1'b0;
            scnt   <= '0;
            lcount <= '0;
        end else begin
            if (ctl_wr && wmask[0])
                en <= wdata[0];
            if (latch_rise)
                scnt <= '0;
            else if (shift_rise && scnt != SCW'(COLS + 1))
                scnt <= scnt + 1'b1;
            if (shift_rise && !latch_rise && scnt >= SCW'(COLS))
                sovf <= 1'b1;
            else if (ctl_wr && wmask[1] && wdata[10])
                sovf <= 1'b0;
            if (lat_drop)
                ovr <= 1'b1;
            else if (ctl_wr && wmask[1] && wdata[9])
                ovr <= 1'b0;
            if (cnt_wr)
                lcount <= '0;
            else if (lat_go)
                lcount <= lcount + 16'd1;
        end
    end

    // Shift and holding registers (data only)
    logic [COLS-1:0] sr   [6];
    logic [COLS-1:0] hold [6];
    logic [RAW-1:0]  row_r;

    always_ff @(posedge clk) begin
        if (shift_rise) begin
            for (int i = 0; i < 6; i++)
                sr[i] <= {rgb_s[i], sr[i][COLS-1:1]};
        end
        if (lat_go) begin
            hold  <= sr;
            row_r <= rowsel_s;
        end
    end

    // Clear engine: one address per cycle, restarted by reset or bus
    logic [AW-1:0] clr_addr;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_start) begin
            clr_busy <= 1'b1;
            clr_addr <= '0;
        end else if (clr_busy) begin
            if (clr_addr == AW'(DEPTH - 1))
                clr_busy <= 1'b0;
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // Accumulate stage p0: issue RAM read for column acc_col
    logic [CW-1:0] acc_col;
    logic [AW-1:0] addr_p1;
    logic [5:0]    bits_p1;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_start) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            acc_col <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (lat_go) begin
                vld_p0  <= 1'b1;
                acc_col <= '0;
            end else if (vld_p0) begin
                acc_col <= acc_col + 1'b1;
                if (acc_col == CW'(COLS - 1))
                    vld_p0 <= 1'b0;
            end
        end
    end

    // Accumulate stage p1: RAM data back, saturating add, write
    always_ff @(posedge clk) begin
        addr_p1 <= {row_r, acc_col};
        for (int i = 0; i < 6; i++)
            bits_p1[i] <= hold[i][acc_col];
    end

    logic [23:0]   ram_top [DEPTH];
    logic [23:0]   ram_bot [DEPTH];
    logic [23:0]   q_top, q_bot, wd_top, wd_bot;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          wr_en;

    always_comb begin
        wr_en   = clr_busy | vld_p1;
        wr_addr = clr_busy ? clr_addr : addr_p1;
        wd_top  = clr_busy ? 24'h0 : sat_acc(q_top, bits_p1[2:0]);
        wd_bot  = clr_busy ? 24'h0 : sat_acc(q_bot, bits_p1[5:3]);
        rd_addr = vld_p0 ? {row_r, acc_col} : pix_addr;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_top[wr_addr] <= wd_top;
            ram_bot[wr_addr] <= wd_bot;
        end
        q_top <= ram_top[rd_addr];
        q_bot <= ram_bot[rd_addr];
    end

    // Bus response FSM; B_DONE swallows the still-held request while ready is high
    logic [31:0] status, reg_rdata;
    logic        half_q;

    assign status    = {20'h0, oe_s, sovf, ovr, busy, 6'h0, 1'b0, en};
    assign reg_rdata = (word == CTL_WORD) ? status :
                       (word == CNT_WORD) ? {16'h0, lcount} : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bstate <= B_IDLE;
            ready  <= 1'b0;
            rdata  <= 32'h0;
            half_q <= 1'b0;
        end else begin
            case (bstate)
                B_IDLE: begin
                    ready <= 1'b0;
                    if (is_rd && is_pix) begin
                        if (!busy) begin
                            half_q <= pix_half;
                            bstate <= B_PIX;
                        end
                    end else if (is_rd) begin
                        rdata  <= reg_rdata;
                        ready  <= 1'b1;
                        bstate <= B_DONE;
                    end else if (is_wr) begin
                        rdata  <= 32'h0;
                        ready  <= 1'b1;
                        bstate <= B_DONE;
                    end
                end
                B_PIX: begin
                    rdata  <= {8'h0, half_q ? q_bot : q_top};
                    ready  <= 1'b1;
                    bstate <= B_DONE;
                end
                default: begin
                    ready  <= 1'b0;
                    bstate <= B_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/hub75_capture.md
# hub75_capture

Bus-attached HUB75 receiver and panel emulator. It samples the six colour lines, row select, shift clock, latch and OE of a HUB75 link, such as the output of the team's HUB75 driver. It accumulates, per pixel and per channel, the number of latched row periods in which that channel was lit. Software or a testbench reads the counts back over the CPU bus to check colour values and PWM duty on real hardware or in simulation.

## Interface
Parameters:
- `ROWS`, 64: panel rows; `ROWS/2` are addressable.
- `COLS`, 64: shift length per row.
- `BASEADDR`, 32'h82000000: bus base address (byte).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  synchronous reset, active-low.
- `addr`  in  32  bus byte address.
- `wdata`  in  32  bus write data.
- `wmask`  in  4  byte write enables.
- `wen`, `ren`  in  1  bus write/read request; held by master until `ready`.
- `rdata`  out  32  read data, registered.
- `ready`  out  1  one-cycle completion pulse.
- `active`  out  1  combinational; `addr` in `[BASEADDR, BASEADDR+4*(ROWS*COLS+2))`.
- `R0 G0 B0 R1 G1 B1`  in  1 each  upper-half / lower-half colour bits.
- `ROWSEL`  in  `$clog2(ROWS/2)`  row address.
- `CLK_HUB75`  in  1  shift clock; data sampled on rising edge.
- `LATCH`  in  1  latch strobe; rising edge.
- `OE`  in  1  output enable, active-low; status only.

## Operation
- Edge detect: a registered previous value of `CLK_HUB75`/`LATCH`; a rise is current=1 and previous=0. Data and `ROWSEL` are taken in the same cycle the rise is seen.
- Shift: six `COLS`-bit shift registers. New bit enters the MSB, shift right; after exactly `COLS` shifts, the first bit is at column 0. A shift counter saturates at `COLS+1` and clears on latch. More than `COLS` shifts set sticky `SOVF`, and the oldest bits are lost.
- Latch (enable=1, engine idle): copy the shift regs to holding regs, capture `ROWSEL` as `r`, increment 16-bit `LCOUNT` (wraps), and start the accumulate engine.
- Latch while engine busy: the latch is dropped (no count, no copy) and sticky `OVR` is set. Latch while enable=0 or clearing: ignored, no flags.
- Accumulate engine: two counter RAMs (top, bottom), `ROWS/2*COLS` x 24 bits, `{B,G,R}` 8 bits each. It pipelines read-modify-write one column per cycle: read `{r,c}` at cycle k, write at k+1. Each 8-bit field adds its channel bit, saturating at 255.
- Clear engine: writes zero to both RAMs, one address per cycle, `ROWS/2*COLS` cycles. Started by control bit 1 and automatically on reset release.
- Address map (word offset from BASEADDR):
  - `0..ROWS*COLS-1`: pixel `row*COLS+col` returns `{8'h0,B,G,R}`. Row `>= ROWS/2` selects the bottom RAM. Writes are ignored, but `ready` still pulses.
  - `ROWS*COLS`: control/status. [0] EN RW, reset 0. [1] CLEAR write-1 start, reads 0. [8] BUSY (clear or accumulate) RO. [9] OVR W1C. [10] SOVF W1C. [11] current `OE` RO.
  - `ROWS*COLS+1`: `{16'h0,LCOUNT}`; a write of any value clears it.
- Engines own the RAM read port. Bus pixel reads stall (no `ready`) while BUSY.

## Timing
- Reset: `rdata`=0, `ready`=0, all flags/counters 0, clear engine started (BUSY=1 from first cycle after reset release).
- Register reads/writes: `ready` and `rdata` valid the cycle after request; one pulse per request; master drops request after `ready`.
- Pixel read, idle: `ready` 2 cycles after request (RAM read + register). When BUSY, 2 cycles after BUSY falls.
- Accumulate: BUSY for `COLS+1` cycles, starting the cycle after the latch rise. Result readable afterward.
- Simultaneous bus CLEAR and latch: clear wins, latch ignored. CLEAR during accumulate: abort accumulate, start clear.
- Reset mid-operation: engines abort, clear restarts.

## Configuration
- `HUB75_CAPTURE_SYNC_EN`: defined → all HUB75 inputs pass through 2-flop synchronizers (external pins, 2-cycle added latency, relative alignment kept). Undefined → inputs used directly (same-clock source, simulation/loopback).

## Test plan
- Reset → `ready`=0, `rdata`=0; BUSY=1 for 2048 cycles then 0; any pixel word reads 0x00000000.
- EN=1; 64 shifts with only R0=1 at shift index 5; latch with ROWSEL=3 → word 197 = 0x00000001, word 2245 = 0, LCOUNT=1.
- 70 shifts then latch → SOVF=1; columns hold last 64 bits; write 0x400 to control → SOVF=0.
- Two latch rises 10 cycles apart → OVR=1, LCOUNT=1.
- 300 latches, all six bits 1, ROWSEL=0 → words 0..63 and 2048..2111 = 0x00FFFFFF.
- Loop from HUB75 driver with pixel (row 40, col 7)=0x804020; EN=1 at driver PWM frame start; after 8160 latches → word 2567 = 0x00804020.
